// File: rtl/dataram_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : dataram_arbiter_if
//  Description : Bus bundle between the CPU/debug requesters, the data-RAM
//                arbiter and the single-port SPRAM.
//  Revision    : 1.0  initial release
// ============================================================================
interface dataram_arbiter_if #(
    parameter int AW = 14,
    parameter int DW = 16
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [3:0]    cpu_mask;
    logic          cpu_ack;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;

    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic [3:0]    dbg_mask;
    logic          dbg_ack;
    logic          dbg_rvalid;
    logic [DW-1:0] dbg_rdata;
    logic          dbg_excl;

    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_wren;
    logic [3:0]    ram_mask;
    logic [DW-1:0] ram_dout;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_mask,
        output cpu_ack, cpu_rvalid, cpu_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_mask, dbg_excl,
        output dbg_ack, dbg_rvalid, dbg_rdata,
        output ram_addr, ram_din, ram_wren, ram_mask,
        input  ram_dout
    );

    // System side: requesters plus the SPRAM itself
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_mask,
        input  cpu_ack, cpu_rvalid, cpu_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_mask, dbg_excl,
        input  dbg_ack, dbg_rvalid, dbg_rdata,
        input  ram_addr, ram_din, ram_wren, ram_mask,
        output ram_dout
    );
endinterface
`default_nettype wire

// File: rtl/dataram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dataram_arbiter
//  Description : Shares one SPRAM between CPU and debug ports; CPU priority
//                with a starvation limit guaranteeing debug progress.
//  Revision    : 1.0  initial release
// ============================================================================
module dataram_arbiter #(
    parameter int AW       = 14,
    parameter int DW       = 16,
    parameter int MAX_WAIT = 15
) (
    input  wire logic        clock,
    input  wire logic        reset_n,
    dataram_arbiter_if.slave bus
);
    localparam int            WW         = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WW-1:0] c_MAX_WAIT = WW'(MAX_WAIT);
    localparam logic [1:0]    c_OWN_NONE = 2'd0;
    localparam logic [1:0]    c_OWN_CPU  = 2'd1;
    localparam logic [1:0]    c_OWN_DBG  = 2'd2;

    logic          w_forced;
    logic          w_grant_cpu;
    logic          w_grant_dbg;
    logic [1:0]    w_owner_next;

    logic [1:0]    r_rd_owner;
    logic [WW-1:0] r_wait_cnt;
    logic          r_cpu_ack;
    logic          r_dbg_ack;
    logic          r_cpu_rvalid;
    logic          r_dbg_rvalid;
    logic [AW-1:0] r_ram_addr;
    logic [DW-1:0] r_ram_din;
    logic          r_ram_wren;
    logic [3:0]    r_ram_mask;

    always_comb begin
        w_forced    = (MAX_WAIT != 0) && (r_wait_cnt == c_MAX_WAIT);
        w_grant_dbg = bus.dbg_req && (bus.dbg_excl || w_forced || !bus.cpu_req);
        w_grant_cpu = bus.cpu_req && !bus.dbg_excl && !w_grant_dbg;
    end

    // Tag the in-flight read so its data returns on the right port two edges later
    always_comb begin
        w_owner_next = c_OWN_NONE;
        if (w_grant_dbg && !bus.dbg_we) begin
            w_owner_next = c_OWN_DBG;
        end else if (w_grant_cpu && !bus.cpu_we) begin
            w_owner_next = c_OWN_CPU;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_owner   <= c_OWN_NONE;
            r_wait_cnt   <= '0;
            r_cpu_ack    <= 1'b0;
            r_dbg_ack    <= 1'b0;
            r_cpu_rvalid <= 1'b0;
            r_dbg_rvalid <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_din    <= '0;
            r_ram_wren   <= 1'b0;
            r_ram_mask   <= 4'h0;
        end else begin
            r_rd_owner   <= w_owner_next;
            r_cpu_ack    <= w_grant_cpu;
            r_dbg_ack    <= w_grant_dbg;
            r_cpu_rvalid <= (r_rd_owner == c_OWN_CPU);
            r_dbg_rvalid <= (r_rd_owner == c_OWN_DBG);

            if (w_grant_dbg) begin
                r_ram_addr <= bus.dbg_addr;
                r_ram_din  <= bus.dbg_wdata;
                r_ram_wren <= bus.dbg_we;
                r_ram_mask <= bus.dbg_we ? bus.dbg_mask : 4'h0;
            end else if (w_grant_cpu) begin
                r_ram_addr <= bus.cpu_addr;
                r_ram_din  <= bus.cpu_wdata;
                r_ram_wren <= bus.cpu_we;
                r_ram_mask <= bus.cpu_we ? bus.cpu_mask : 4'h0;
            end else begin
                r_ram_wren <= 1'b0;
                r_ram_mask <= 4'h0;
            end

            if (!bus.dbg_req || w_grant_dbg) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt != c_MAX_WAIT) begin
                r_wait_cnt <= r_wait_cnt + WW'(1);
            end
        end
    end

    assign bus.cpu_ack    = r_cpu_ack;
    assign bus.dbg_ack    = r_dbg_ack;
    assign bus.cpu_rvalid = r_cpu_rvalid;
    assign bus.dbg_rvalid = r_dbg_rvalid;
    assign bus.cpu_rdata  = bus.ram_dout;
    assign bus.dbg_rdata  = bus.ram_dout;
    assign bus.ram_addr   = r_ram_addr;
    assign bus.ram_din    = r_ram_din;
    assign bus.ram_wren   = r_ram_wren;
    assign bus.ram_mask   = r_ram_mask;
endmodule
`default_nettype wire
